sprite_engine: RTL

//  Per-scanline sprite renderer: on sprite_start it scans a NUM_SPRITES attribute table.
//  For every enabled sprite that covers target_line, it fetches one 16-pixel row from the

---
 rtl/sprite_engine.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sprite_engine.sv
// Per-scanline sprite renderer: scans the attribute table from the highest index down and
// streams opaque pixels of every sprite row that covers target_line into the linebuffer.
module sprite_engine #(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned LINE_W      = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        attr_we,
  input  logic [5:0]  attr_addr,
  input  logic [31:0] attr_wdata,
  input  logic        sprite_start,
  input  logic [9:0]  target_line,
  output logic [13:0] rom_addr,
  input  logic [15:0] rom_q,
  output logic [9:0]  lb_addr,
  output logic [15:0] lb_data,
  output logic        lb_we,
  output logic        busy,
  output logic        sprite_done
);

  localparam int unsigned IW = $clog2(NUM_SPRITES);

  typedef enum logic [2:0] {StIdle, StCheck, StFetch, StDrain, StDone} state_e;

  // Stored entry: [9:0] x, [18:10] y, [24:19] frame, [25] hflip, [26] enable.
  logic [26:0]   attr_q [NUM_SPRITES];
  logic [26:0]   attr_d [NUM_SPRITES];
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    col_q, col_d;
  logic          drain_q, drain_d;
  logic [9:0]    line_q, line_d;
  logic [13:0]   rom_addr_q, rom_addr_d;
  logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [10:0]   s1_x_q, s1_x_d, s2_x_q, s2_x_d;
  logic          lb_we_q, lb_we_d;
  logic [9:0]    lb_addr_q, lb_addr_d;
  logic [15:0]   lb_data_q, lb_data_d;

  logic [26:0] cur;
  logic [9:0]  cur_x, cur_y, row;
  logic [5:0]  cur_frame;
  logic        cur_hflip, cur_en, hit;

  // Reserved attribute bits and unused high index bits are deliberately ignored.
  logic unused_attr;
  assign unused_attr = ^{attr_wdata[30:26], attr_addr};

  assign cur       = attr_q[idx_q];
  assign cur_x     = cur[9:0];
  assign cur_y     = {1'b0, cur[18:10]};
  assign cur_frame = cur[24:19];
  assign cur_hflip = cur[25];
  assign cur_en    = cur[26];
  assign row       = line_q - cur_y;
  // No vertical wrap: a sprite below the target line never hits.
  assign hit       = cur_en && (line_q >= cur_y) && (row < 10'd16);

  always_comb begin
    attr_d = attr_q;
    if (attr_we) begin
      attr_d[attr_addr[IW-1:0]] = {attr_wdata[31], attr_wdata[25:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    drain_d    = drain_q;
    line_d     = line_q;
    rom_addr_d = rom_addr_q;
    s1_vld_d   = 1'b0;
    s1_x_d     = s1_x_q;
    unique case (state_q)
      StIdle: begin
        if (sprite_start) begin
          line_d  = target_line;
          idx_d   = IW'(NUM_SPRITES - 1);
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (hit) begin
          col_d   = 4'd0;
          state_d = StFetch;
        end else if (idx_q == '0) begin
          drain_d = 1'b0;
          state_d = StDrain;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StFetch: begin
        rom_addr_d = {cur_frame, row[3:0], cur_hflip ? ~col_q : col_q};
        s1_vld_d   = 1'b1;
        s1_x_d     = {1'b0, cur_x} + 11'(col_q);
        col_d      = col_q + 4'd1;
        if (col_q == 4'd15) begin
          if (idx_q == '0) begin
            drain_d = 1'b0;
            state_d = StDrain;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StCheck;
          end
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write pipeline: address stage, ROM data stage, then the registered linebuffer write.
  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_x_d    = s1_x_q;
    lb_we_d   = s2_vld_q && rom_q[0] && (s2_x_q < 11'(LINE_W));
    lb_addr_d = lb_we_d ? s2_x_q[9:0] : lb_addr_q;
    lb_data_d = lb_we_d ? rom_q : lb_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) attr_q[i] <= '0;
      state_q    <= StIdle;
      idx_q      <= '0;
      col_q      <= '0;
      drain_q    <= 1'b0;
      line_q     <= '0;
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_x_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_x_q     <= '0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else begin
      attr_q     <= attr_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      drain_q    <= drain_d;
      line_q     <= line_d;
      rom_addr_q <= rom_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_x_q     <= s1_x_d;
      s2_vld_q   <= s2_vld_d;
      s2_x_q     <= s2_x_d;
      lb_we_q    <= lb_we_d;
      lb_addr_q  <= lb_addr_d;
      lb_data_q  <= lb_data_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign lb_we       = lb_we_q;
  assign lb_addr     = lb_addr_q;
  assign lb_data     = lb_data_q;
  assign busy        = (state_q != StIdle);
  assign sprite_done = (state_q == StDone);

endmodule
